// File: rtl/kypd_pkg.sv
// rtl/kypd_pkg.sv - shared types and key map for the KYPD 4x4 keypad scanner
package kypd_pkg;

    typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_REL} kypd_state_t;

    typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_res_t;

    // Entry {row,col}: r0 = 1 2 3 A, r1 = 4 5 6 B, r2 = 7 8 9 C, r3 = 0 F E D
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hE, 4'hF, 4'h0,
        4'hC, 4'h9, 4'h8, 4'h7,
        4'hB, 4'h6, 4'h5, 4'h4,
        4'hA, 4'h3, 4'h2, 4'h1
    };

    localparam logic [3:0] KEY_BACKSPACE = 4'hD;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        return KEY_MAP[{r, c}];
    endfunction

endpackage

// File: rtl/kypd_col_scan.sv
// rtl/kypd_col_scan.sv - row synchronizer, column rotation and per-frame classification
module kypd_col_scan
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic       frame_done,
    output frame_res_t frame_res,
    output logic [3:0] key
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0] div;
    logic [1:0]    slot;
    logic [3:0]    row_m;
    logic [3:0]    row_s;
    logic [1:0]    acc_hits;
    logic [3:0]    acc_key;
    logic          slot_end;
    logic [2:0]    cur_hits;
    logic [1:0]    cur_row;
    logic [2:0]    sum_hits;
    logic [1:0]    tot_hits;
    logic [3:0]    tot_key;

    assign slot_end = (div == DW'(SCAN_DIV - 1));
    assign col      = ~(4'b0001 << slot);

    // Hits saturate at 2: anything beyond one low row in a frame is MULTI.
    always_comb begin
        cur_hits = '0;
        cur_row  = '0;
        for (int r = 0; r < 4; r++) begin
            if (!row_s[r]) begin
                cur_hits = cur_hits + 3'd1;
                cur_row  = 2'(r);
            end
        end
        sum_hits = {1'b0, acc_hits} + cur_hits;
        tot_hits = (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
        tot_key  = (cur_hits == 3'd1) ? key_lookup(cur_row, slot) : acc_key;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div        <= '0;
            slot       <= '0;
            row_m      <= 4'hF;
            row_s      <= 4'hF;
            acc_hits   <= '0;
            acc_key    <= '0;
            frame_done <= 1'b0;
            frame_res  <= NONE;
            key        <= '0;
        end else begin
            row_m      <= row;
            row_s      <= row_m;
            frame_done <= 1'b0;
            if (slot_end) begin
                div  <= '0;
                slot <= slot + 2'd1;
                if (slot == 2'd3) begin
                    frame_done <= 1'b1;
                    frame_res  <= (tot_hits == 2'd0) ? NONE :
                                  (tot_hits == 2'd1) ? SINGLE : MULTI;
                    key        <= tot_key;
                    acc_hits   <= '0;
                    acc_key    <= '0;
                end else begin
                    acc_hits <= tot_hits;
                    acc_key  <= tot_key;
                end
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: rtl/kypd_scanner.sv
// rtl/kypd_scanner.sv - keypad scanner top with debounce FSM; KYPD_TYPEMATIC_EN adds auto-repeat
module kypd_scanner
    import kypd_pkg::*;
#(
    parameter int SCAN_DIV       = 100000,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KYPD_TYPEMATIC_EN
    ,
    parameter int REPEAT_SCANS   = 500
`endif
) (
    input  logic       CLK100MHZ,
    input  logic       reset,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] BCD,
    output logic       newVal,
    output logic       valid
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);

    logic        frame_done;
    frame_res_t  frame_res;
    logic [3:0]  key;

    kypd_state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n, cnt_inc;
    logic [3:0]  cand, cand_n, bcd_n;
    logic        newval_n, valid_n;
    logic        reach;

`ifdef KYPD_TYPEMATIC_EN
    localparam int RW = $clog2(REPEAT_SCANS + 1);
    logic [RW-1:0] rep_cnt, rep_cnt_n, rep_inc;
    assign rep_inc = rep_cnt + RW'(1);
`endif

    kypd_col_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk        (CLK100MHZ),
        .rst        (reset),
        .row        (row),
        .col        (col),
        .frame_done (frame_done),
        .frame_res  (frame_res),
        .key        (key)
    );

    assign cnt_inc = (cnt == CW'(DEBOUNCE_SCANS)) ? cnt : cnt + CW'(1);
    assign reach   = (cnt_inc == CW'(DEBOUNCE_SCANS));

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cand_n   = cand;
        bcd_n    = BCD;
        newval_n = newVal;
        valid_n  = valid;
`ifdef KYPD_TYPEMATIC_EN
        rep_cnt_n = rep_cnt;
`endif
        if (frame_done) begin
            case (state)
                IDLE: begin
                    if (frame_res == SINGLE) begin
                        cand_n = key;
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n  = PRESSED;
                            cnt_n    = '0;
                            bcd_n    = key;
                            newval_n = 1'b1;
                            valid_n  = 1'b1;
                        end else begin
                            state_n = DEB_PRESS;
                            cnt_n   = CW'(1);
                        end
                    end
                end
                DEB_PRESS: begin
                    if (frame_res == SINGLE && key == cand) begin
                        if (reach) begin
                            state_n  = PRESSED;
                            cnt_n    = '0;
                            bcd_n    = cand;
                            newval_n = 1'b1;
                            valid_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                PRESSED: begin
                    if (frame_res == NONE) begin
                        if (DEBOUNCE_SCANS == 1) begin
                            state_n  = IDLE;
                            newval_n = 1'b0;
                        end else begin
                            state_n = DEB_REL;
                            cnt_n   = CW'(1);
                        end
                    end
`ifdef KYPD_TYPEMATIC_EN
                    else begin
                        // A one-frame low pulse gives downstream another falling edge to commit on.
                        if (rep_inc == RW'(REPEAT_SCANS)) begin
                            newval_n  = 1'b0;
                            rep_cnt_n = '0;
                        end else begin
                            newval_n  = 1'b1;
                            rep_cnt_n = rep_inc;
                        end
                    end
`endif
                end
                DEB_REL: begin
                    if (frame_res == NONE) begin
                        if (reach) begin
                            state_n  = IDLE;
                            cnt_n    = '0;
                            newval_n = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else if (frame_res == SINGLE && key == cand) begin
                        state_n  = PRESSED;
                        cnt_n    = '0;
                        newval_n = 1'b1;
                    end else begin
                        state_n  = IDLE;
                        cnt_n    = '0;
                        newval_n = 1'b0;
                    end
                end
                default: begin
                    state_n  = IDLE;
                    cnt_n    = '0;
                    newval_n = 1'b0;
                end
            endcase
        end
`ifdef KYPD_TYPEMATIC_EN
        if (state_n != PRESSED) begin
            rep_cnt_n = '0;
        end
`endif
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            cand   <= '0;
            BCD    <= '0;
            newVal <= 1'b0;
            valid  <= 1'b0;
`ifdef KYPD_TYPEMATIC_EN
            rep_cnt <= '0;
`endif
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cand   <= cand_n;
            BCD    <= bcd_n;
            newVal <= newval_n;
            valid  <= valid_n;
`ifdef KYPD_TYPEMATIC_EN
            rep_cnt <= rep_cnt_n;
`endif
        end
    end

endmodule
